// File: rtl/seq_magnitude_comparator_pkg.sv
// seq_magnitude_comparator_pkg: shared state enum, result encoding and digit-count helper.
// The package is named cmp_pkg. It holds:
//   state_t                  IDLE / SCAN / DONE
//   RES_EQ / RES_GT / RES_LT one-hot {eq,gt,lt} result codes
//   calc_ndig(width, digit)  returns width/digit, or 0 when width is not a multiple of digit
package cmp_pkg;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   localparam logic [2:0] RES_NONE = 3'b000;
   localparam logic [2:0] RES_EQ   = 3'b100;
   localparam logic [2:0] RES_GT   = 3'b010;
   localparam logic [2:0] RES_LT   = 3'b001;
   function automatic int calc_ndig(input int width, input int digit);
      return (digit > 0 && width % digit == 0) ? width / digit : 0;
   endfunction
endpackage

// File: rtl/seq_magnitude_comparator_if.sv
// seq_magnitude_comparator_if: start/done compare bus.
// Signals:
//   start, a, b, signed_mode   request side (master drives these)
//   busy, done, eq, gt, lt     status/result side (slave drives these)
// Modports: master (requester), slave (comparator).
interface seq_magnitude_comparator_if #(parameter int WIDTH = 32);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             busy;
   logic             done;
   logic             eq;
   logic             gt;
   logic             lt;
   modport master (output start, a, b, signed_mode, input busy, done, eq, gt, lt);
   modport slave  (input start, a, b, signed_mode, output busy, done, eq, gt, lt);
endinterface

// File: rtl/seq_magnitude_comparator_digit_compare.sv
// digit_compare: combinational unsigned compare of one DIGIT-bit slice.
// Ports:
//   i_a, i_b       DIGIT-bit slices
//   i_msb_invert   flip both slice MSBs first (offset-binary for a signed top slice)
//   o_eq/o_gt/o_lt compare result
module digit_compare #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] i_a,
   input  logic [DIGIT-1:0] i_b,
   input  logic             i_msb_invert,
   output logic             o_eq,
   output logic             o_gt,
   output logic             o_lt
);
   logic [DIGIT-1:0] w_inv;
   logic [DIGIT-1:0] w_a;
   logic [DIGIT-1:0] w_b;
   assign w_inv = DIGIT'(i_msb_invert) << (DIGIT - 1);
   assign w_a   = i_a ^ w_inv;
   assign w_b   = i_b ^ w_inv;
   assign o_eq  = w_a == w_b;
   assign o_gt  = w_a > w_b;
   assign o_lt  = w_a < w_b;
endmodule

// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle MSB-first magnitude comparator, DIGIT bits per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_magnitude_comparator_if.slave (start/a/b/signed_mode in; busy/done/eq/gt/lt out)
// Parameters: WIDTH (multiple of DIGIT), DIGIT (bits per scan cycle).
// Macro SEQ_CMP_EARLY_EXIT_EN: when defined, leave SCAN on the first differing slice.
module seq_magnitude_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input logic                      clk,
   input logic                      rst_n,
   seq_magnitude_comparator_if.slave bus
);
   localparam int NDIG = calc_ndig(WIDTH, DIGIT);
   localparam int IW   = NDIG > 1 ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST = IW'(NDIG - 1);
   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_sm;
   logic [IW-1:0]    r_idx;
   logic             r_dec;
   logic             r_dgt;
   logic             r_busy;
   logic             r_done;
   logic [2:0]       r_res;
   logic             w_eq;
   logic             w_gt;
   logic             w_lt;
   logic             w_hit;
   logic             w_dec;
   logic             w_dgt;
   logic             w_end;
   digit_compare #(.DIGIT(DIGIT)) u_dc (
      .i_a         (r_a[r_idx*DIGIT +: DIGIT]),
      .i_b         (r_b[r_idx*DIGIT +: DIGIT]),
      .i_msb_invert(r_sm && r_idx == LAST),
      .o_eq        (w_eq),
      .o_gt        (w_gt),
      .o_lt        (w_lt)
   );
   // First differing slice from the MSB end decides; later slices are ignored.
   assign w_hit = !r_dec && !w_eq;
   assign w_dec = r_dec || w_hit;
   assign w_dgt = w_hit ? w_gt : r_dgt;
`ifdef SEQ_CMP_EARLY_EXIT_EN
   assign w_end = r_idx == '0 || w_hit;
`else
   assign w_end = r_idx == '0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_sm    <= 1'b0;
         r_idx   <= '0;
         r_dec   <= 1'b0;
         r_dgt   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_res   <= RES_NONE;
      end else if (r_state == SCAN) begin
         if (w_end) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_res   <= !w_dec ? RES_EQ : w_dgt ? RES_GT : RES_LT;
         end else begin
            r_idx <= r_idx - 1'b1;
            r_dec <= w_dec;
            r_dgt <= w_dgt;
         end
      end else begin
         r_done <= 1'b0;
         if (bus.start) begin
            r_state <= SCAN;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sm    <= bus.signed_mode;
            r_idx   <= LAST;
            r_dec   <= 1'b0;
            r_dgt   <= 1'b0;
            r_busy  <= 1'b1;
         end else begin
            r_state <= IDLE;
         end
      end
   end
   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign {bus.eq, bus.gt, bus.lt} = r_res;
   logic w_unused;
   assign w_unused = w_lt;
endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: directed checks of an 8-bit/4-bit and a 32-bit/1-bit comparator.
module tb_seq_magnitude_comparator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   always #5 clk = ~clk;
`ifdef SEQ_CMP_EARLY_EXIT_EN
   localparam int L1 = 1;
`else
   localparam int L1 = 32;
`endif
   seq_magnitude_comparator_if #(.WIDTH(8))  if0 ();
   seq_magnitude_comparator_if #(.WIDTH(32)) if1 ();
   seq_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   seq_magnitude_comparator #(.WIDTH(32), .DIGIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic run0(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sm, input logic [2:0] exp);
      int n = 0;
      @(negedge clk);
      if0.start = 1'b1; if0.a = a; if0.b = b; if0.signed_mode = sm;
      @(posedge clk); #1;
      if0.start = 1'b0; if0.a = ~a; if0.b = ~b; if0.signed_mode = ~sm;
      chk({tag, "_busy"}, 32'(if0.busy), 32'd1);
      while (!if0.done && n < 40) begin @(posedge clk); #1; n++; end
      chk({tag, "_lat"}, n, 32'd2);
      chk({tag, "_res"}, {if0.eq, if0.gt, if0.lt}, exp);
      chk({tag, "_idle"}, 32'(if0.busy), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {if0.done, if0.eq, if0.gt, if0.lt}, {1'b0, exp});
   endtask
   task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sm, input logic [2:0] exp, input int lat);
      int n = 0;
      @(negedge clk);
      if1.start = 1'b1; if1.a = a; if1.b = b; if1.signed_mode = sm;
      @(posedge clk); #1;
      if1.start = 1'b0; if1.a = ~a; if1.b = ~b;
      while (!if1.done && n < 100) begin @(posedge clk); #1; n++; end
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_res"}, {if1.eq, if1.gt, if1.lt}, exp);
   endtask
   initial begin
      int n;
      logic seen;
      if0.start = 1'b0; if0.a = '0; if0.b = '0; if0.signed_mode = 1'b0;
      if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.signed_mode = 1'b0;
      #12;
      chk("rst0", {if0.busy, if0.done, if0.eq, if0.gt, if0.lt}, 32'd0);
      chk("rst1", {if1.busy, if1.done, if1.eq, if1.gt, if1.lt}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("pre_res", {if0.done, if0.eq, if0.gt, if0.lt}, 32'd0);
      run0("u255_0",  8'd255, 8'd0,  1'b0, 3'b010);
      run0("u50_75",  8'd50,  8'd75, 1'b0, 3'b001);
      run0("eq15",    8'd15,  8'd15, 1'b0, 3'b100);
      run0("low_lt",  8'h35,  8'h3A, 1'b0, 3'b001);
      run0("high_gt", 8'h5A,  8'h4F, 1'b0, 3'b010);
      run0("s_m1_1",  8'hFF,  8'h01, 1'b1, 3'b001);
      run0("u_ff_1",  8'hFF,  8'h01, 1'b0, 3'b010);
      run0("s_80_7f", 8'h80,  8'h7F, 1'b1, 3'b001);
      run0("s_7f_80", 8'h7F,  8'h80, 1'b1, 3'b010);
      // start held high through the scan: one done, nothing queued
      @(negedge clk);
      if0.start = 1'b1; if0.a = 8'h10; if0.b = 8'h20; if0.signed_mode = 1'b0;
      @(posedge clk); #1;
      n = 0;
      while (!if0.done && n < 40) begin @(posedge clk); #1; n++; end
      if0.start = 1'b0;
      chk("hold_lat", n, 32'd2);
      chk("hold_res", {if0.eq, if0.gt, if0.lt}, 3'b001);
      seen = 1'b0;
      repeat (5) begin @(posedge clk); #1; seen |= if0.done | if0.busy; end
      chk("hold_single", 32'(seen), 32'd0);
      // start in the DONE cycle: accepted immediately
      @(negedge clk);
      if0.start = 1'b1; if0.a = 8'h44; if0.b = 8'h44;
      @(posedge clk); #1;
      if0.start = 1'b0;
      while (!if0.done && n < 80) begin @(posedge clk); #1; n++; end
      if0.start = 1'b1; if0.a = 8'h01; if0.b = 8'h02;
      @(posedge clk); #1;
      if0.start = 1'b0;
      chk("b2b_first", {if0.busy, if0.done, if0.eq, if0.gt, if0.lt}, {2'b10, 3'b100});
      n = 1;
      while (!if0.done && n < 40) begin @(posedge clk); #1; n++; end
      chk("b2b_gap", n, 32'd3);
      chk("b2b_res", {if0.eq, if0.gt, if0.lt}, 3'b001);
      // reset mid-scan: clears everything and no done follows
      @(negedge clk);
      if0.start = 1'b1; if0.a = 8'h90; if0.b = 8'h10;
      @(posedge clk); #1;
      if0.start = 1'b0;
      @(posedge clk); #1;
      chk("mid_busy", 32'(if0.busy), 32'd1);
      @(negedge clk); rst_n = 1'b0; #1;
      chk("mid_rst", {if0.busy, if0.done, if0.eq, if0.gt, if0.lt}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin @(posedge clk); #1; seen |= if0.done | if0.busy; end
      chk("mid_no_done", 32'(seen), 32'd0);
      run1("w_msb_gt", 32'h8000_0000, 32'h0, 1'b0, 3'b010, L1);
      run1("w_eq", 32'h1234_5678, 32'h1234_5678, 1'b0, 3'b100, 32);
      run1("w_s_lt", 32'h8000_0000, 32'h0, 1'b1, 3'b001, L1);
      run1("w_lsb_lt", 32'h0000_0000, 32'h0000_0001, 1'b0, 3'b001, 32);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
